// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: combinational decode/execute from an external ROM,
// 32x32 register file and a private word-organised data RAM.
module rv32i_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  output logic [31:0] pc_addr
);

  localparam int AW = $clog2(DMEM_WORDS);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0]    opcode;
  logic [4:0]    rd, rs1, rs2, shamt;
  logic [2:0]    funct3;
  logic          funct7_5;
  logic [31:0]   rs1_data, rs2_data, imm, alu_b, alu_result, wdata;
  logic          reg_write, branch_taken;
  logic [31:0]   pc_plus4, mem_addr, target, next_pc;
  logic [31:0]   load_word, load_val;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic [AW-1:0] mem_idx;
  logic          unused_bits;

  logic [31:0] regs [32];
  logic [31:0] dmem [DMEM_WORDS];

  assign opcode   = instr[6:0];
  assign rd       = instr[11:7];
  assign funct3   = instr[14:12];
  assign rs1      = instr[19:15];
  assign rs2      = instr[24:20];
  assign funct7_5 = instr[30];

  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
  assign pc_plus4 = pc_addr + 32'd4;

  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (opcode)
      OPC_LUI, OPC_AUIPC: imm = {instr[31:12], 12'd0};
      OPC_JAL:    imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPC_BRANCH: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_STORE:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      default:    ;
    endcase
  end

  // Non-ALU opcodes fall through to rs1+imm, which serves as load/store/JALR address
  always_comb begin
    alu_b      = (opcode == OPC_OP) ? rs2_data : imm;
    shamt      = alu_b[4:0];
    alu_result = rs1_data + alu_b;
    if (opcode == OPC_OP || opcode == OPC_OPIMM) begin
      case (funct3)
        3'b000:  alu_result = (opcode == OPC_OP && funct7_5) ? rs1_data - alu_b : rs1_data + alu_b;
        3'b001:  alu_result = rs1_data << shamt;
        3'b010:  alu_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
        3'b011:  alu_result = {31'd0, rs1_data < alu_b};
        3'b100:  alu_result = rs1_data ^ alu_b;
        3'b101:  alu_result = funct7_5 ? 32'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
        3'b110:  alu_result = rs1_data | alu_b;
        default: alu_result = rs1_data & alu_b;
      endcase
    end
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000:  branch_taken = (rs1_data == rs2_data);
      3'b001:  branch_taken = (rs1_data != rs2_data);
      3'b100:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
      3'b101:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  branch_taken = (rs1_data < rs2_data);
      3'b111:  branch_taken = (rs1_data >= rs2_data);
      default: ;
    endcase
  end

  assign mem_addr  = alu_result;
  assign mem_idx   = mem_addr[AW+1:2];
  assign load_word = dmem[mem_idx];
  assign load_byte = load_word[{mem_addr[1:0], 3'b000} +: 8];
  assign load_half = mem_addr[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_val = load_word;
    case (funct3)
      3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_val = {{16{load_half[15]}}, load_half};
      3'b100:  load_val = {24'd0, load_byte};
      3'b101:  load_val = {16'd0, load_half};
      default: ;
    endcase
  end

  always_comb begin
    reg_write = 1'b0;
    wdata     = alu_result;
    case (opcode)
      OPC_LUI:             begin reg_write = 1'b1; wdata = imm;            end
      OPC_AUIPC:           begin reg_write = 1'b1; wdata = pc_addr + imm;  end
      OPC_JAL, OPC_JALR:   begin reg_write = 1'b1; wdata = pc_plus4;       end
      OPC_LOAD:            begin reg_write = 1'b1; wdata = load_val;       end
      OPC_OPIMM, OPC_OP:   begin reg_write = 1'b1; wdata = alu_result;     end
      default:             ;
    endcase
  end

  always_comb begin
    target = pc_plus4;
    case (opcode)
      OPC_JAL:    target = pc_addr + imm;
      OPC_JALR:   target = alu_result & ~32'd1;
      OPC_BRANCH: if (branch_taken) target = pc_addr + imm;
      default:    ;
    endcase
    next_pc = {target[31:2], 2'b00};
  end

  assign unused_bits = ^{mem_addr[31:AW+2], target[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_addr <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      pc_addr <= next_pc;
      if (reg_write && rd != 5'd0) regs[rd] <= wdata;
    end
  end

  // Stores are suppressed while reset is held so a stalled PC cannot repeat a write
  always_ff @(posedge clk) begin
    if (rst_n && opcode == OPC_STORE) begin
      case (funct3)
        3'b000: dmem[mem_idx][{mem_addr[1:0], 3'b000} +: 8] <= rs2_data[7:0];
        3'b001: begin
          if (mem_addr[1]) dmem[mem_idx][31:16] <= rs2_data[15:0];
          else             dmem[mem_idx][15:0]  <= rs2_data[15:0];
        end
        3'b010:  dmem[mem_idx] <= rs2_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_core.sv
// Self-checking bench for rv32i_core: directed program plus a random program
// checked against an instruction-level interpreter.
module tb_rv32i_core;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13, OPR = 7'h33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc_addr;

  logic [31:0] rom [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc;

  int tests = 0;
  int failed = 0;

  rv32i_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .instr  (instr),
    .pc_addr(pc_addr)
  );

  always #5 clk = ~clk;
  assign instr = rom[pc_addr[9:2]];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    int nz;
    rst_n = 1'b0;
    #20;
    nz = 0;
    for (int i = 0; i < 32; i++) if (dut.regs[i] !== 32'd0) nz++;
    checkOutput("reset_pc", pc_addr, 32'd0);
    checkOutput("reset_regs_nonzero", nz, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  function automatic logic [31:0] encI(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] encR(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPR};
  endfunction
  function automatic logic [31:0] encS(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], ST};
  endfunction
  function automatic logic [31:0] encB(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], BR};
  endfunction
  function automatic logic [31:0] encU(int imm20, int rd, logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] encJ(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], JAL};
  endfunction

  // Architectural interpreter: executes the instruction at m_pc on the model state
  task automatic modelStep(output bit we, output logic [4:0] rdn, output logic [31:0] val);
    logic [31:0] ins, a, b, op2, iI, iS, iB, iU, iJ, addr, word, npc;
    logic [2:0]  f3;
    int          sh, sh16;
    ins  = rom[m_pc[9:2]];
    a    = m_regs[ins[19:15]];
    b    = m_regs[ins[24:20]];
    f3   = ins[14:12];
    rdn  = ins[11:7];
    iI   = 32'($signed(ins) >>> 20);
    iS   = {iI[31:5], ins[11:7]};
    iB   = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    iU   = {ins[31:12], 12'h000};
    iJ   = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    we   = 1'b0;
    val  = 32'd0;
    npc  = m_pc + 32'd4;
    addr = a + ((ins[6:0] == ST) ? iS : iI);
    word = m_mem[addr[9:2]];
    sh   = 8 * int'(addr[1:0]);
    sh16 = addr[1] ? 16 : 0;
    case (ins[6:0])
      LUI:   begin we = 1'b1; val = iU; end
      AUIPC: begin we = 1'b1; val = m_pc + iU; end
      JAL:   begin we = 1'b1; val = m_pc + 32'd4; npc = m_pc + iJ; end
      JALR:  begin we = 1'b1; val = m_pc + 32'd4; npc = (a + iI) & 32'hFFFF_FFFE; end
      BR: begin
        case (f3)
          3'd0: if (a == b) npc = m_pc + iB;
          3'd1: if (a != b) npc = m_pc + iB;
          3'd4: if ($signed(a) < $signed(b)) npc = m_pc + iB;
          3'd5: if ($signed(a) >= $signed(b)) npc = m_pc + iB;
          3'd6: if (a < b) npc = m_pc + iB;
          3'd7: if (a >= b) npc = m_pc + iB;
          default: ;
        endcase
      end
      LD: begin
        we = 1'b1;
        case (f3)
          3'd0: val = 32'($signed(word << (24 - sh)) >>> 24);
          3'd1: val = 32'($signed(word << (16 - sh16)) >>> 16);
          3'd4: val = (word >> sh) & 32'hFF;
          3'd5: val = (word >> sh16) & 32'hFFFF;
          default: val = word;
        endcase
      end
      ST: begin
        case (f3)
          3'd0: m_mem[addr[9:2]] = (word & ~(32'hFF << sh)) | ((b & 32'hFF) << sh);
          3'd1: m_mem[addr[9:2]] = (word & ~(32'hFFFF << sh16)) | ((b & 32'hFFFF) << sh16);
          3'd2: m_mem[addr[9:2]] = b;
          default: ;
        endcase
      end
      OPI, OPR: begin
        we  = 1'b1;
        op2 = (ins[6:0] == OPR) ? b : iI;
        case (f3)
          3'd0: val = (ins[6:0] == OPR && ins[30]) ? a - op2 : a + op2;
          3'd1: val = a << op2[4:0];
          3'd2: val = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
          3'd3: val = (a < op2) ? 32'd1 : 32'd0;
          3'd4: val = a ^ op2;
          3'd5: val = ins[30] ? 32'($signed(a) >>> op2[4:0]) : a >> op2[4:0];
          3'd6: val = a | op2;
          default: val = a & op2;
        endcase
      end
      default: ;
    endcase
    if (we && rdn != 5'd0) m_regs[rdn] = val;
    m_pc = {npc[31:2], 2'b00};
  endtask

  function automatic logic [31:0] randInstr();
    int k, rd, rs1, rs2, f3, imm;
    int ldf[5] = '{0, 1, 2, 4, 5};
    int brf[6] = '{0, 1, 4, 5, 6, 7};
    k   = $urandom_range(0, 99);
    rd  = $urandom_range(0, 31);
    rs1 = $urandom_range(0, 31);
    rs2 = $urandom_range(0, 31);
    f3  = $urandom_range(0, 7);
    imm = $urandom_range(0, 4095);
    if (k < 30) begin
      if (f3 == 1) imm = imm & 31;
      if (f3 == 5) imm = (imm & 31) | ($urandom_range(0, 1) ? 32'h400 : 32'h0);
      return encI(imm, rs1, f3, rd, OPI);
    end else if (k < 55) begin
      return encR(((f3 == 0 || f3 == 5) && $urandom_range(0, 1)) ? 32'h20 : 0, rs2, rs1, f3, rd);
    end else if (k < 62) return encU($urandom, rd, LUI);
    else if (k < 67) return encU($urandom, rd, AUIPC);
    else if (k < 75) return encI($urandom_range(0, 63), 0, ldf[$urandom_range(0, 4)], rd, LD);
    else if (k < 83) return encS($urandom_range(0, 63), rs2, 0, $urandom_range(0, 2));
    else if (k < 92) return encB(4 * $urandom_range(1, 8), rs2, rs1, brf[$urandom_range(0, 5)]);
    else if (k < 95) return encJ(4 * $urandom_range(1, 8), rd);
    else if (k < 97) return encI(imm, rs1, 0, rd, JALR);
    else if (k < 98) return 32'h0000_0073;
    else if (k < 99) return 32'h0000_000F;
    return 32'h0000_0000;
  endfunction

  initial begin
    bit          we;
    logic [4:0]  rdn;
    logic [31:0] val;

    // Directed program
    for (int i = 0; i < 256; i++) rom[i] = 32'd0;
    rom[0]  = encI(5, 0, 0, 1, OPI);
    rom[1]  = encI(-3, 1, 0, 2, OPI);
    rom[2]  = encI(7, 0, 0, 0, OPI);
    rom[3]  = encR(0, 2, 1, 0, 3);
    rom[4]  = encR(32'h20, 1, 2, 0, 4);
    rom[5]  = encU(32'h12345, 5, LUI);
    rom[6]  = encI(32'h678, 5, 0, 5, OPI);
    rom[7]  = encS(0, 5, 0, 2);
    rom[8]  = encB(8, 1, 1, 0);
    rom[9]  = encI(1, 0, 0, 31, OPI);
    rom[10] = encB(8, 1, 1, 1);
    rom[11] = encI(3, 0, 0, 6, LD);
    rom[12] = encI(0, 0, 4, 7, LD);
    rom[13] = encI(2, 0, 1, 8, LD);
    rom[14] = encI(-1, 0, 0, 9, OPI);
    rom[15] = encB(8, 1, 9, 6);
    rom[16] = encJ(16, 1);
    rom[17] = encB(8, 1, 9, 4);
    rom[18] = encI(1, 0, 0, 31, OPI);
    rom[19] = encJ(12, 0);
    rom[20] = encI(0, 1, 0, 0, JALR);
    rom[23] = 32'h0000_0073;
    rom[24] = encI(32'h72, 0, 0, 10, OPI);
    rom[25] = encI(1, 10, 0, 11, JALR);
    rom[26] = encI(1, 0, 0, 31, OPI);
    rom[27] = encI(1, 0, 0, 31, OPI);
    rom[28] = encS(1, 9, 0, 0);
    rom[29] = encS(2, 1, 0, 1);
    rom[30] = encI(0, 0, 2, 12, LD);

    applyReset();
    checkOutput("pc_after_release", pc_addr, 32'h0);
    applyStimulus(1);
    checkOutput("pc_step1", pc_addr, 32'h4);
    checkOutput("x1_addi", dut.regs[1], 32'd5);
    checkOutput("imm_neg", dut.imm, 32'hFFFF_FFFD);
    checkOutput("wdata_addi", dut.wdata, 32'd2);
    applyStimulus(1);
    checkOutput("pc_step2", pc_addr, 32'h8);
    checkOutput("x2_addi", dut.regs[2], 32'd2);
    checkOutput("reg_write_x0", dut.reg_write, 1'b1);
    applyStimulus(1);
    checkOutput("x0_zero", dut.regs[0], 32'd0);
    applyStimulus(1);
    checkOutput("x3_add", dut.regs[3], 32'd7);
    applyStimulus(1);
    checkOutput("x4_sub", dut.regs[4], 32'hFFFF_FFFD);
    applyStimulus(2);
    checkOutput("x5_lui_addi", dut.regs[5], 32'h1234_5678);
    applyStimulus(2);
    checkOutput("beq_taken_pc", pc_addr, 32'h28);
    applyStimulus(1);
    checkOutput("bne_not_taken_pc", pc_addr, 32'h2C);
    applyStimulus(1);
    checkOutput("x6_lb", dut.regs[6], 32'h0000_0012);
    applyStimulus(1);
    checkOutput("x7_lbu", dut.regs[7], 32'h0000_0078);
    applyStimulus(1);
    checkOutput("x8_lh", dut.regs[8], 32'h0000_1234);
    applyStimulus(2);
    checkOutput("bltu_not_taken_pc", pc_addr, 32'h40);
    applyStimulus(1);
    checkOutput("jal_pc", pc_addr, 32'h50);
    checkOutput("jal_link", dut.regs[1], 32'h44);
    applyStimulus(1);
    checkOutput("jalr_pc", pc_addr, 32'h44);
    applyStimulus(1);
    checkOutput("blt_taken_pc", pc_addr, 32'h4C);
    applyStimulus(1);
    checkOutput("jal_x0_pc", pc_addr, 32'h58);
    applyStimulus(2);
    checkOutput("nop_ecall_pc", pc_addr, 32'h60);
    applyStimulus(2);
    checkOutput("jalr_align_pc", pc_addr, 32'h70);
    checkOutput("jalr_link", dut.regs[11], 32'h68);
    applyStimulus(3);
    checkOutput("x12_sb_sh_lw", dut.regs[12], 32'h0044_FF78);
    checkOutput("x31_untouched", dut.regs[31], 32'd0);

    // Asynchronous reset mid-program
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_pc", pc_addr, 32'd0);
    checkOutput("midreset_x12", dut.regs[12], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1);
    checkOutput("midreset_restart_pc", pc_addr, 32'h4);

    // Random program: prologue zeroes the RAM window that random loads touch
    for (int i = 0; i < 16; i++) rom[i] = encS(4 * i, 0, 0, 2);
    for (int i = 16; i < 256; i++) rom[i] = randInstr();
    for (int i = 0; i < 256; i++) m_mem[i] = 32'd0;
    applyReset();
    for (int c = 0; c < 2000; c++) begin
      checkOutput("rand_pc", pc_addr, m_pc);
      modelStep(we, rdn, val);
      if (we) checkOutput("rand_wdata", dut.wdata, val);
      applyStimulus(1);
      checkOutput("rand_reg", dut.regs[rdn], m_regs[rdn]);
    end
    for (int i = 0; i < 32; i++) checkOutput("final_reg", dut.regs[i], m_regs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
